// File: rtl/io_pkg.sv
// io_pkg: shared constants and helpers for the I/O interrupt bridge
package io_pkg;
  localparam int IO_DATA_W = 16;
  localparam int MAX_DEV   = 15;
  localparam int CTRL_GIE  = 15;
  localparam int CTRL_OVF  = 14;
  localparam int CTRL_SEL  = 15;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [3:0] prio_enc(input logic [MAX_DEV-1:0] v);
    prio_enc = '0;
    for (int i = MAX_DEV - 1; i >= 0; i--)
      if (v[i]) prio_enc = 4'(i);
  endfunction
endpackage

// File: rtl/io_irq_bridge_ret_stack.sv
// ret_stack: circular return-address stack that overwrites its oldest entry when full
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         overflow
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr, ptr_m1;
  logic [PW:0]   cnt;
  logic          empty, full, repl;

  assign ptr_m1   = ptr - PW'(1);
  assign empty    = cnt == '0;
  assign full     = cnt == (PW+1)'(DEPTH);
  assign repl     = push & pop & ~empty;
  assign top      = empty ? '0 : mem[ptr_m1];
  assign overflow = push & ~repl & full;

  // Pointer and occupancy: store advances, pop retreats, store+pop replaces the top in place.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push & ~repl) begin
      ptr <= ptr + PW'(1);
      cnt <= full ? cnt : cnt + (PW+1)'(1);
    end else if (pop & ~push & ~empty) begin
      ptr <= ptr_m1;
      cnt <= cnt - (PW+1)'(1);
    end

  // Entry storage; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk)
    if (push) mem[repl ? ptr_m1 : ptr] <= din;
endmodule

// File: rtl/io_irq_bridge.sv
// io_irq_bridge: CPU I/O bus bridge with device decode, interrupt controller and return stack
module io_irq_bridge
  import io_pkg::*;
#(
  parameter int N_DEV     = 3,
  parameter int DATA_W    = IO_DATA_W,
  parameter int RET_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read,
  input  logic                    write,
  input  logic                    push,
  input  logic                    push_ints,
  input  logic                    push_int_addr,
  input  logic                    store_retaddr,
  input  logic                    push_retaddr,
  output logic                    interrupt,
  inout  wire  [DATA_W-1:0]       d_addr,
  inout  wire  [DATA_W-1:0]       d_bus,
  output logic [N_DEV-1:0]        dev_read,
  output logic [N_DEV-1:0]        dev_write,
  output logic [N_DEV*DATA_W-1:0] dev_wdata,
  input  logic [N_DEV*DATA_W-1:0] dev_rdata,
  input  logic [N_DEV-1:0]        dev_irq
);
  logic [N_DEV-1:0]  dev_bits, dsel, irq_q, pending, mask, active, act_lo, ack_clr;
  logic              gie, ovf, ctrl_sel, ctrl_we, stk_ovf, bus_en;
  logic [3:0]        idx;
  logic [DATA_W-1:0] dev_sel_data, ctrl_val, bus_val, stk_top;

  // Lowest set address bit wins; unmapped bits below the CTRL select still block CTRL.
  assign dev_bits = d_addr[N_DEV-1:0];
  assign dsel     = dev_bits & (~dev_bits + N_DEV'(1));
  assign ctrl_sel = d_addr[CTRL_SEL] & ~|d_addr[CTRL_SEL-1:0];
  assign ctrl_we  = write & ctrl_sel;

  assign active    = pending & mask;
  assign act_lo    = active & (~active + N_DEV'(1));
  assign ack_clr   = push_int_addr ? act_lo : '0;
  assign idx       = prio_enc(MAX_DEV'(active));
  assign interrupt = gie & |active;

  assign dev_read  = (rst_n & read) ? dsel : '0;
  assign dev_write = (rst_n & write) ? dsel : '0;

  for (genvar g = 0; g < N_DEV; g++) begin : g_wdata
    assign dev_wdata[g*DATA_W +: DATA_W] = (rst_n & dsel[g]) ? d_bus : '0;
  end

  // Selected channel read data and the CTRL register image.
  always_comb begin
    dev_sel_data = '0;
    for (int i = 0; i < N_DEV; i++)
      if (dsel[i]) dev_sel_data = dev_rdata[i*DATA_W +: DATA_W];
    ctrl_val = '0;
    ctrl_val[N_DEV-1:0] = mask;
    ctrl_val[CTRL_OVF] = ovf;
    ctrl_val[CTRL_GIE] = gie;
  end

  assign bus_val = push ? (ctrl_sel ? ctrl_val : dev_sel_data)
                 : push_retaddr ? stk_top : DATA_W'(active);
  assign bus_en  = rst_n & (push | push_retaddr | push_ints);
  assign d_bus   = bus_en ? bus_val : 'z;
  assign d_addr  = (rst_n & push_int_addr) ? DATA_W'(idx) : 'z;

  // Interrupt edge capture, acknowledge and CTRL register; a new edge beats a same-cycle ack.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '0;
      gie     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      irq_q   <= dev_irq;
      pending <= (pending & ~ack_clr) | (dev_irq & ~irq_q);
      if (ctrl_we) begin
        mask <= d_bus[N_DEV-1:0];
        gie  <= d_bus[CTRL_GIE];
      end else if (push_int_addr) begin
        gie <= 1'b0;
      end
      ovf <= stk_ovf | (ovf & ~ctrl_we);
    end

  ret_stack #(.DEPTH(RET_DEPTH), .W(DATA_W)) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (store_retaddr),
    .pop      (push_retaddr),
    .din      (d_bus),
    .top      (stk_top),
    .overflow (stk_ovf)
  );
endmodule
